// File: rtl/fp_accum_seq.sv
// Packet reduction sequencer feeding a pipelined IEEE-754 single-precision adder.
// Accepts floats on a valid/ready stream and emits the packet sum and element count.
module fp_accum_seq #(
   parameter int EXP_W   = 8,
   parameter int MAN_W   = 23,
   parameter int ADD_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   in_data,
   input  logic                   in_last,
   output logic [EXP_W+MAN_W:0]   add_in1,
   output logic [EXP_W+MAN_W:0]   add_in2,
   input  logic [EXP_W+MAN_W:0]   add_out,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   out_data,
   output logic [CNT_W-1:0]       out_count
);

   localparam int DW    = EXP_W + MAN_W + 1;
   localparam int LAT_W = (ADD_LAT < 2) ? 1 : $clog2(ADD_LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACC,
      S_ADD,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [DW-1:0]    acc_q, acc_d;
   logic [DW-1:0]    op_b_q, op_b_d;
   logic [DW-1:0]    add_in1_q, add_in1_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   logic             last_q, last_d;

   logic             in_zero;
   logic             acc_zero;
   logic [CNT_W-1:0] count_inc;

   // A zero exponent field (true zero or denormal) never reaches the adder.
   assign in_zero   = (in_data[MAN_W +: EXP_W] == '0);
   assign acc_zero  = (acc_q[MAN_W +: EXP_W] == '0);
   assign count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
      state_d   = state_q;
      acc_d     = acc_q;
      op_b_d    = op_b_q;
      add_in1_d = add_in1_q;
      count_d   = count_q;
      lat_d     = lat_q;
      last_d    = last_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready = rst;
            if (in_valid && rst) begin
               acc_d   = in_data;
               count_d = CNT_W'(1);
               state_d = in_last ? S_DONE : S_ACC;
            end
         end

         S_ACC: begin
            in_ready = rst;
            if (in_valid && rst) begin
               count_d = count_inc;
               if (in_zero) begin
                  state_d = in_last ? S_DONE : S_ACC;
               end else if (acc_zero) begin
                  acc_d   = in_data;
                  state_d = in_last ? S_DONE : S_ACC;
               end else begin
                  op_b_d    = in_data;
                  add_in1_d = acc_q;
                  lat_d     = '0;
                  last_d    = in_last;
                  state_d   = S_ADD;
               end
            end
         end

         S_ADD: begin
            // Operands stay frozen in add_in1_q/op_b_q until the adder result is due.
            if (lat_q == LAT_W'(ADD_LAT)) begin
               acc_d   = add_out;
               state_d = last_q ? S_DONE : S_ACC;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end

         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               acc_d   = '0;
               count_d = '0;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: the async reset clears every state register, so a reset mid-packet discards the partial sum.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         op_b_q    <= '0;
         add_in1_q <= '0;
         count_q   <= '0;
         lat_q     <= '0;
         last_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking updates so all registers see the pre-edge values of each other.
         state_q   <= state_d;
         acc_q     <= acc_d;
         op_b_q    <= op_b_d;
         add_in1_q <= add_in1_d;
         count_q   <= count_d;
         lat_q     <= lat_d;
         last_q    <= last_d;
      end
   end

   assign add_in1   = add_in1_q;
   assign add_in2   = op_b_q;
   assign out_data  = acc_q;
   assign out_count = count_q;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Scoreboard bench for fp_accum_seq: one instance with a 1-stage adder model, one with 3 stages.
module tb_fp_accum_seq;

   typedef struct {
      logic [31:0] data;
      logic [15:0] cnt;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [31:0] in_data   [2];
   logic        in_last   [2];
   logic [31:0] add_in1   [2];
   logic [31:0] add_in2   [2];
   logic [31:0] add_out   [2];
   logic        out_valid [2];
   logic        out_ready [2];
   logic [31:0] out_data  [2];
   logic [15:0] out_count [2];

   exp_t exp_q0[$];
   exp_t exp_q1[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;

   always #5 clk = ~clk;

   fp_accum_seq #(.EXP_W(8), .MAN_W(23), .ADD_LAT(1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
      .add_in1(add_in1[0]), .add_in2(add_in2[0]), .add_out(add_out[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
      .out_count(out_count[0])
   );

   fp_accum_seq #(.EXP_W(8), .MAN_W(23), .ADD_LAT(3), .CNT_W(16)) dut3 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
      .add_in1(add_in1[1]), .add_in2(add_in2[1]), .add_out(add_out[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
      .out_count(out_count[1])
   );

   // Truncating float adder for normal operands; exact for the small values used here.
   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [7:0]  e, d;
      logic [25:0] mx, my, m;
      if (a[30:0] >= b[30:0]) begin x = a; y = b; end
      else begin x = b; y = a; end
      e  = x[30:23];
      d  = x[30:23] - y[30:23];
      mx = {3'b001, x[22:0]};
      my = (d > 8'd25) ? 26'd0 : ({3'b001, y[22:0]} >> d);
      if (x[31] == y[31]) begin
         m = mx + my;
         if (m[24]) begin m = m >> 1; e = e + 8'd1; end
      end else begin
         m = mx - my;
         if (m == 26'd0) return 32'd0;
         while (!m[23]) begin m = m << 1; e = e - 8'd1; end
      end
      return {x[31], e, m[22:0]};
   endfunction

   logic [31:0] pipe0;
   logic [31:0] pipe1 [3];
   always @(posedge clk) begin
      pipe0    <= fadd(add_in1[0], add_in2[0]);
      pipe1[0] <= fadd(add_in1[1], add_in2[1]);
      pipe1[1] <= pipe1[0];
      pipe1[2] <= pipe1[1];
   end
   assign add_out[0] = pipe0;
   assign add_out[1] = pipe1[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic push(input int i, input logic [31:0] d, input logic [15:0] c);
      exp_t e;
      e.data = d;
      e.cnt  = c;
      if (i == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
   endtask

   task automatic sb_step(input int i);
      exp_t e;
      int   n;
      n = (i == 0) ? exp_q0.size() : exp_q1.size();
      if (n == 0) begin
         chk_cnt++;
         $display("FAIL sb%0d_unexpected: out_data %h count %0d with nothing expected",
                  i, out_data[i], out_count[i]);
      end else begin
         e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         check($sformatf("sb%0d_data", i), out_data[i], e.data);
         check($sformatf("sb%0d_count", i), 32'(out_count[i]), 32'(e.cnt));
      end
   endtask

   initial forever begin
      @(negedge clk);
      if (out_valid[0] && out_ready[0]) sb_step(0);
   end

   initial forever begin
      @(negedge clk);
      if (out_valid[1] && out_ready[1]) sb_step(1);
   end

   // Offer one element; 'busy' negedges of expected in_ready=0 (adder running) come first.
   task automatic send(input int i, input logic [31:0] d, input logic l,
                       input int busy, input logic [31:0] a1, input logic [31:0] a2);
      int n = 0;
      in_valid[i] = 1'b1;
      in_data[i]  = d;
      in_last[i]  = l;
      for (int k = 0; k < busy; k++) begin
         @(negedge clk);
         check($sformatf("busy_ready%0d", i), 32'(in_ready[i]), 32'd0);
         check($sformatf("add_in1_%0d", i), add_in1[i], a1);
         check($sformatf("add_in2_%0d", i), add_in2[i], a2);
      end
      @(negedge clk);
      while (!in_ready[i] && n < 50) begin
         n++;
         @(negedge clk);
      end
      check($sformatf("accept_wait%0d", i), 32'(n), 32'd0);
      @(posedge clk);
      #1;
      in_valid[i] = 1'b0;
      in_last[i]  = 1'b0;
   endtask

   task automatic expect_done(input int i, input int busy, input logic [31:0] a1, input logic [31:0] a2);
      for (int k = 0; k < busy; k++) begin
         @(negedge clk);
         check($sformatf("add_valid%0d", i), 32'(out_valid[i]), 32'd0);
         check($sformatf("add_ready%0d", i), 32'(in_ready[i]), 32'd0);
         check($sformatf("add_hold1_%0d", i), add_in1[i], a1);
         check($sformatf("add_hold2_%0d", i), add_in2[i], a2);
      end
      @(negedge clk);
      check($sformatf("done_valid%0d", i), 32'(out_valid[i]), 32'd1);
      check($sformatf("done_ready%0d", i), 32'(in_ready[i]), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic run_t1(input int i, input int busy);
      push(i, 32'h40C00000, 16'd3);
      send(i, 32'h3F800000, 1'b0, 0, 32'h0, 32'h0);
      send(i, 32'h40000000, 1'b0, 0, 32'h0, 32'h0);
      send(i, 32'h40400000, 1'b1, busy, 32'h3F800000, 32'h40000000);
      expect_done(i, busy, 32'h40400000, 32'h40400000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         in_valid[i]  = 1'b0;
         in_data[i]   = 32'h0;
         in_last[i]   = 1'b0;
         out_ready[i] = 1'b1;
      end
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(in_ready[0]), 32'd0);
      check("rst_valid", 32'(out_valid[0]), 32'd0);
      check("rst_add_in1", add_in1[0], 32'h0);
      check("rst_add_in2", add_in2[0], 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(in_ready[0]), 32'd1);
      @(posedge clk);
      #1;

      // T1: 1 + 2 + 3 back-to-back
      run_t1(0, 2);

      // T2: zero first element bypasses; no add, in_ready never drops
      push(0, 32'h40400000, 16'd2);
      send(0, 32'h00000000, 1'b0, 0, 32'h0, 32'h0);
      send(0, 32'h40400000, 1'b1, 0, 32'h0, 32'h0);
      expect_done(0, 0, 32'h0, 32'h0);

      // T3: single element
      push(0, 32'hC1200000, 16'd1);
      send(0, 32'hC1200000, 1'b1, 0, 32'h0, 32'h0);
      expect_done(0, 0, 32'h0, 32'h0);

      // T4: 5 + (-3) with output back-pressure
      out_ready[0] = 1'b0;
      push(0, 32'h40000000, 16'd2);
      send(0, 32'h40A00000, 1'b0, 0, 32'h0, 32'h0);
      send(0, 32'hC0400000, 1'b1, 0, 32'h0, 32'h0);
      expect_done(0, 2, 32'h40A00000, 32'hC0400000);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_valid", 32'(out_valid[0]), 32'd1);
         check("hold_data", out_data[0], 32'h40000000);
         check("hold_count", 32'(out_count[0]), 32'd2);
         check("hold_ready", 32'(in_ready[0]), 32'd0);
      end
      @(posedge clk);
      #1;
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("t4_idle_valid", 32'(out_valid[0]), 32'd0);
      check("t4_idle_ready", 32'(in_ready[0]), 32'd1);
      @(posedge clk);
      #1;

      // T5: reset during the add of the second element
      send(0, 32'h3F800000, 1'b0, 0, 32'h0, 32'h0);
      send(0, 32'h40000000, 1'b0, 0, 32'h0, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      check("t5_rst_valid", 32'(out_valid[0]), 32'd0);
      check("t5_rst_ready", 32'(in_ready[0]), 32'd0);
      repeat (2) @(negedge clk);
      check("t5_rst_ready_hold", 32'(in_ready[0]), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("t5_rel_ready", 32'(in_ready[0]), 32'd1);
      check("t5_rel_valid", 32'(out_valid[0]), 32'd0);
      @(posedge clk);
      #1;
      push(0, 32'h3F800000, 16'd1);
      send(0, 32'h3F800000, 1'b1, 0, 32'h0, 32'h0);
      expect_done(0, 0, 32'h0, 32'h0);

      // T6: T1 on the 3-stage adder instance
      run_t1(1, 4);

      repeat (4) @(negedge clk);
      check("sb0_drained", 32'(exp_q0.size()), 32'd0);
      check("sb1_drained", 32'(exp_q1.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
